// File: rtl/cache_port_arbiter.sv
// cache_port_arbiter: round-robin two-port arbiter in front of the change-triggered cache_2way path.
// Optional ARB_STATS_EN adds saturating grant/read-miss counters. Rev 1.0
`default_nettype none

module cache_port_arbiter #(
  parameter int AW          = 32,
  parameter int DW          = 32,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          p0_req,
  input  logic          p0_wr,
  input  logic [AW-1:0] p0_addr,
  input  logic [DW-1:0] p0_data,
  output logic          p0_ack,
  output logic [DW-1:0] p0_rdata,
  input  logic          p1_req,
  input  logic          p1_wr,
  input  logic [AW-1:0] p1_addr,
  input  logic [DW-1:0] p1_data,
  output logic          p1_ack,
  output logic [DW-1:0] p1_rdata,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_data,
  output logic          mem_wr,
  input  logic          mem_response,
  input  logic          mem_is_missrate,
  input  logic [DW-1:0] mem_out,
  output logic          busy,
  output logic          timeout_err
`ifdef ARB_STATS_EN
  ,
  output logic [15:0]   stat_gnt0,
  output logic [15:0]   stat_gnt1,
  output logic [15:0]   stat_miss
`endif
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ISSUE  = 3'd1;
  localparam logic [2:0] S_SETTLE = 3'd2;
  localparam logic [2:0] S_WAIT   = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYC - 1);

  logic [2:0]    state;
  logic          last_grant;
  logic          gnt;
  logic          op_wr;
  logic [7:0]    wait_cnt;
  logic [DW-1:0] cap_data;
  logic          cap_miss;
  logic          pick1;

  // Port 1 wins when it is alone, or on a tie when port 0 had the previous grant.
  assign pick1 = p1_req & (~p0_req | ~last_grant);
  assign busy  = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      last_grant  <= 1'b1;
      gnt         <= 1'b0;
      op_wr       <= 1'b0;
      wait_cnt    <= 8'd0;
      cap_data    <= '0;
      cap_miss    <= 1'b0;
      mem_addr    <= '0;
      mem_data    <= '0;
      mem_wr      <= 1'b0;
      p0_ack      <= 1'b0;
      p1_ack      <= 1'b0;
      p0_rdata    <= '0;
      p1_rdata    <= '0;
      timeout_err <= 1'b0;
`ifdef ARB_STATS_EN
      stat_gnt0   <= 16'd0;
      stat_gnt1   <= 16'd0;
      stat_miss   <= 16'd0;
`endif
    end else begin
      p0_ack <= 1'b0;
      p1_ack <= 1'b0;
      case (state)
        S_IDLE: begin
          if (p0_req || p1_req) begin
            gnt      <= pick1;
            op_wr    <= pick1 ? p1_wr   : p0_wr;
            mem_wr   <= pick1 ? p1_wr   : p0_wr;
            mem_addr <= pick1 ? p1_addr : p0_addr;
            mem_data <= pick1 ? p1_data : p0_data;
            state    <= S_ISSUE;
`ifdef ARB_STATS_EN
            if (pick1) begin
              if (stat_gnt1 != 16'hFFFF) stat_gnt1 <= stat_gnt1 + 16'd1;
            end else begin
              if (stat_gnt0 != 16'hFFFF) stat_gnt0 <= stat_gnt0 + 16'd1;
            end
`endif
          end
        end
        S_ISSUE: state <= S_SETTLE;
        // A hit keeps response high, so the response level is not trusted until WAIT.
        S_SETTLE: begin
          wait_cnt <= 8'd0;
          state    <= S_WAIT;
        end
        S_WAIT: begin
          if (mem_response) begin
            cap_data <= mem_out;
            cap_miss <= mem_is_missrate;
            state    <= S_DONE;
          end else if (wait_cnt == TO_LAST) begin
            timeout_err <= 1'b1;
            cap_data    <= '0;
            cap_miss    <= 1'b0;
            state       <= S_DONE;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        S_DONE: begin
          if (gnt) begin
            p1_ack <= 1'b1;
            if (!op_wr) p1_rdata <= cap_data;
          end else begin
            p0_ack <= 1'b1;
            if (!op_wr) p0_rdata <= cap_data;
          end
          last_grant <= gnt;
          state      <= S_IDLE;
`ifdef ARB_STATS_EN
          if (cap_miss && !op_wr && stat_miss != 16'hFFFF) stat_miss <= stat_miss + 16'd1;
`endif
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire
